// File: rtl/sram_trng_extract.sv
// Von Neumann debiaser for raw SRAM power-up bytes read from the capture RAM.
// Packs unbiased bits MSB-first into bytes on a valid/ready stream and tracks raw bias.
module sram_trng_extract #(
  parameter int ADDR_W    = 10,
  parameter int NUM_BYTES = 1
) (
  input  logic              uprocessor_clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_q,
  output logic [7:0]        out_byte,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W+3:0] ones_cnt,
  output logic [ADDR_W:0]   out_cnt,
  output logic [2:0]        leftover_bits
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BYTES - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT1 = 3'd1,
    WAIT2 = 3'd2,
    PAIR0 = 3'd3,
    PAIR1 = 3'd4,
    PAIR2 = 3'd5,
    PAIR3 = 3'd6,
    DONE  = 3'd7
  } state_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  state_t      state_r;
  logic [7:0]  raw_r;
  logic [6:0]  acc_r;
  logic [2:0]  acc_n_r;

  logic        pair_a_s;
  logic        pair_b_s;
  logic        in_pair_s;
  logic        emit_s;
  logic        full_s;
  logic        free_s;
  logic        stall_s;
  logic        load_s;
  logic [6:0]  acc_next_s;
  logic [2:0]  acc_n_next_s;

  // Select the bit pair examined by the current PAIRk state.
  always_comb begin
    pair_a_s  = 1'b0;
    pair_b_s  = 1'b0;
    in_pair_s = 1'b0;
    case (state_r)
      PAIR0: begin pair_a_s = raw_r[7]; pair_b_s = raw_r[6]; in_pair_s = 1'b1; end
      PAIR1: begin pair_a_s = raw_r[5]; pair_b_s = raw_r[4]; in_pair_s = 1'b1; end
      PAIR2: begin pair_a_s = raw_r[3]; pair_b_s = raw_r[2]; in_pair_s = 1'b1; end
      PAIR3: begin pair_a_s = raw_r[1]; pair_b_s = raw_r[0]; in_pair_s = 1'b1; end
      default: begin
        pair_a_s  = 1'b0;
        pair_b_s  = 1'b0;
        in_pair_s = 1'b0;
      end
    endcase
  end

  // Debias decision, output-register availability and accumulator next state.
  always_comb begin
    emit_s       = in_pair_s && (pair_a_s != pair_b_s);
    full_s       = emit_s && (acc_n_r == 3'd7);
    free_s       = !out_valid || out_ready;
    stall_s      = full_s && !free_s;
    load_s       = full_s && free_s;
    acc_next_s   = acc_r;
    acc_n_next_s = acc_n_r;
    if (load_s) begin
      acc_n_next_s = 3'd0;
    end else if (emit_s && !full_s) begin
      acc_next_s   = {acc_r[5:0], pair_a_s};
      acc_n_next_s = acc_n_r + 3'd1;
    end else begin
      acc_next_s   = acc_r;
      acc_n_next_s = acc_n_r;
    end
  end

  // Run sequencer, packer and output stream register.
  always_ff @(posedge uprocessor_clk) begin
    if (rst) begin
      state_r       <= IDLE;
      raw_r         <= 8'h00;
      acc_r         <= 7'd0;
      acc_n_r       <= 3'd0;
      ram_addr      <= {ADDR_W{1'b0}};
      out_byte      <= 8'h00;
      out_valid     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      ones_cnt      <= {(ADDR_W+4){1'b0}};
      out_cnt       <= {(ADDR_W+1){1'b0}};
      leftover_bits <= 3'd0;
    end else begin
      if (load_s) begin
        out_byte  <= {acc_r, pair_a_s};
        out_valid <= 1'b1;
        out_cnt   <= out_cnt + CNT_ONE;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      // A stalled 8th bit is re-evaluated next cycle, so the accumulator must not move.
      if (!stall_s) begin
        acc_r   <= acc_next_s;
        acc_n_r <= acc_n_next_s;
      end

      case (state_r)
        IDLE: begin
          if (start) begin
            state_r       <= WAIT1;
            busy          <= 1'b1;
            ram_addr      <= {ADDR_W{1'b0}};
            ones_cnt      <= {(ADDR_W+4){1'b0}};
            out_cnt       <= {(ADDR_W+1){1'b0}};
            acc_r         <= 7'd0;
            acc_n_r       <= 3'd0;
            leftover_bits <= 3'd0;
          end
        end
        WAIT1: state_r <= WAIT2;
        WAIT2: begin
          raw_r    <= ram_q;
          ones_cnt <= ones_cnt + {{ADDR_W{1'b0}}, popcount8(ram_q)};
          state_r  <= PAIR0;
        end
        PAIR0: if (!stall_s) state_r <= PAIR1;
        PAIR1: if (!stall_s) state_r <= PAIR2;
        PAIR2: if (!stall_s) state_r <= PAIR3;
        PAIR3: begin
          if (!stall_s) begin
            if (ram_addr < LAST_ADDR) begin
              ram_addr <= ram_addr + ADDR_ONE;
              state_r  <= WAIT1;
            end else begin
              leftover_bits <= acc_n_next_s;
              done          <= 1'b1;
              state_r       <= DONE;
            end
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_trng_extract.sv
// Directed bench for sram_trng_extract: three instances (NUM_BYTES 1, 2, 4) share a
// capture-RAM image; a run-level model predicts every output cycle by cycle.
module tb_sram_trng_extract;

  localparam int AW = 10;

  logic          clk;
  logic          rst;
  logic          out_ready;
  logic          start_v     [3];
  logic [AW-1:0] ram_addr_v  [3];
  logic [7:0]    out_byte_v  [3];
  logic          out_valid_v [3];
  logic          busy_v      [3];
  logic          done_v      [3];
  logic [AW+3:0] ones_v      [3];
  logic [AW:0]   outc_v      [3];
  logic [2:0]    left_v      [3];
  logic [7:0]    mem         [4];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int NB = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    logic [7:0] q;
    always @(posedge clk) q <= mem[ram_addr_v[g][1:0]];
    sram_trng_extract #(.ADDR_W(AW), .NUM_BYTES(NB)) u_dut (
      .uprocessor_clk (clk),
      .rst            (rst),
      .start          (start_v[g]),
      .ram_addr       (ram_addr_v[g]),
      .ram_q          (q),
      .out_byte       (out_byte_v[g]),
      .out_valid      (out_valid_v[g]),
      .out_ready      (out_ready),
      .busy           (busy_v[g]),
      .done           (done_v[g]),
      .ones_cnt       (ones_v[g]),
      .out_cnt        (outc_v[g]),
      .leftover_bits  (left_v[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks;
  int         errors;
  int         sel;
  int         t;
  bit         trk;
  bit         timed;
  bit         held;
  logic [7:0] held_byte;
  int         done_cnt;
  int         done_t;
  int         xfers;

  // run model: image, expected bytes and the cycle each byte appears
  int         n;
  logic [7:0] img [4];
  int         nbits;
  int         ones_tot;
  logic [7:0] exp_bytes [$];
  int         vt [$];
  logic [7:0] sb [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0d)", nm, act, exp, t);
    end
  endtask

  task automatic build(input int nn);
    int   cur;
    logic a;
    logic b;
    n = nn;
    nbits = 0;
    ones_tot = 0;
    cur = 0;
    exp_bytes.delete();
    vt.delete();
    for (int i = 0; i < 4; i++) img[i] = mem[i];
    for (int by = 0; by < nn; by++) begin
      ones_tot += $countones(img[by]);
      for (int k = 0; k < 4; k++) begin
        a = img[by][7-2*k];
        b = img[by][6-2*k];
        if (a != b) begin
          cur = (cur << 1) | int'(a);
          nbits++;
          if (nbits % 8 == 0) begin
            exp_bytes.push_back(8'(cur));
            vt.push_back(6*by + 3 + k);
            cur = 0;
          end
        end
      end
    end
    sb = exp_bytes;
  endtask

  task automatic compare();
    int s_ones;
    int s_oc;
    bit v_exp;
    if (done_v[sel]) begin
      done_cnt++;
      done_t = t;
      chk("done_ones_cnt", 32'(ones_v[sel]), ones_tot);
      chk("done_out_cnt", 32'(outc_v[sel]), nbits / 8);
      chk("done_leftover", 32'(left_v[sel]), nbits % 8);
    end
    if (timed) begin
      s_ones = 0;
      for (int by = 0; by < n; by++) if (6*by + 2 <= t) s_ones += $countones(img[by]);
      s_oc = 0;
      v_exp = 1'b0;
      foreach (vt[i]) begin
        if (vt[i] <= t) s_oc++;
        if (vt[i] == t) v_exp = 1'b1;
      end
      chk("busy", 32'(busy_v[sel]), 32'(t <= 6*n));
      chk("done", 32'(done_v[sel]), 32'(t == 6*n));
      chk("out_valid", 32'(out_valid_v[sel]), 32'(v_exp));
      chk("ram_addr", 32'(ram_addr_v[sel]), (t/6 < n-1) ? t/6 : n-1);
      chk("ones_cnt", 32'(ones_v[sel]), s_ones);
      chk("out_cnt", 32'(outc_v[sel]), s_oc);
      chk("leftover", 32'(left_v[sel]), (t >= 6*n) ? nbits % 8 : 0);
    end
    if (out_valid_v[sel]) begin
      if (out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL xfer_extra actual=%02h required=none (t=%0d)", out_byte_v[sel], t);
        end else begin
          chk("xfer_byte", 32'(out_byte_v[sel]), 32'(sb.pop_front()));
        end
        xfers++;
        held = 1'b0;
      end else begin
        if (held) chk("hold_stable", 32'(out_byte_v[sel]), 32'(held_byte));
        held = 1'b1;
        held_byte = out_byte_v[sel];
      end
    end else begin
      held = 1'b0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (trk) compare();
    t++;
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int s);
    sel = s;
    start_v[s] = 1'b1;
    @(posedge clk);
    #1;
    start_v[s] = 1'b0;
    t = 0;
    trk = 1'b1;
    held = 1'b0;
    done_cnt = 0;
    done_t = -1;
    xfers = 0;
  endtask

  task automatic run_timed(input int s, input int nn, input bit pulse);
    build(nn);
    out_ready = 1'b1;
    timed = 1'b1;
    launch(s);
    repeat (6*nn + 4) begin
      step();
      start_v[s] = pulse && (t == 8 || t == 20);
    end
    trk = 1'b0;
    timed = 1'b0;
    chk("run_done_pulses", done_cnt, 1);
    chk("run_done_cycle", done_t, 6*nn);
    chk("run_xfers", xfers, exp_bytes.size());
    chk("run_sb_empty", sb.size(), 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    sel = 0;
    t = 0;
    trk = 1'b0;
    timed = 1'b0;
    held = 1'b0;
    held_byte = 8'h00;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
    for (int i = 0; i < 4; i++) mem[i] = 8'h00;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      chk("rst_outputs", {out_byte_v[g], 2'(ram_addr_v[g]), out_valid_v[g], busy_v[g], done_v[g]}, 32'h0);
      chk("rst_counters", {11'(ones_v[g]), 11'(outc_v[g]), left_v[g]}, 32'h0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 0x9A, one byte: four bits, nothing emitted
    mem[0] = 8'h9A;
    build(1);
    chk("model_9a_bits", nbits, 4);
    chk("model_9a_ones", ones_tot, 4);
    run_timed(0, 1, 1'b0);
    chk("9a_leftover", 32'(left_v[0]), 32'h4);
    chk("9a_ones", 32'(ones_v[0]), 32'h4);
    chk("9a_out_cnt", 32'(outc_v[0]), 32'h0);
    chk("9a_done_at_7th", done_t, 6);

    // 0xAA,0x55: single byte 0xF0 after byte 2 PAIR3
    mem[0] = 8'hAA; mem[1] = 8'h55;
    build(2);
    chk("model_aa55_byte", 32'(exp_bytes[0]), 32'hF0);
    chk("model_aa55_time", vt[0], 12);
    run_timed(1, 2, 1'b0);
    chk("aa55_out_cnt", 32'(outc_v[1]), 32'h1);
    chk("aa55_ones", 32'(ones_v[1]), 32'h8);
    chk("aa55_leftover", 32'(left_v[1]), 32'h0);

    // 0x00,0xFF: all pairs equal
    mem[0] = 8'h00; mem[1] = 8'hFF;
    run_timed(1, 2, 1'b0);
    chk("00ff_out_cnt", 32'(outc_v[1]), 32'h0);
    chk("00ff_ones", 32'(ones_v[1]), 32'h8);

    // backpressure: 0xFF held, FSM stalls on the second byte
    mem[0] = 8'hAA; mem[1] = 8'hAA; mem[2] = 8'h55; mem[3] = 8'h55;
    build(4);
    out_ready = 1'b0;
    timed = 1'b0;
    launch(2);
    while (t < 44) step();
    chk("bp_hold_byte", 32'(out_byte_v[2]), 32'hFF);
    chk("bp_hold_valid", 32'(out_valid_v[2]), 32'h1);
    chk("bp_stall_busy", 32'(busy_v[2]), 32'h1);
    chk("bp_no_done", done_cnt, 0);
    chk("bp_stall_addr", 32'(ram_addr_v[2]), 32'h3);
    chk("bp_stall_out_cnt", 32'(outc_v[2]), 32'h1);
    out_ready = 1'b1;
    for (int i = 0; i < 40 && done_cnt == 0; i++) step();
    chk("bp_done_seen", done_cnt, 1);
    repeat (3) step();
    trk = 1'b0;
    chk("bp_xfers", xfers, 2);
    chk("bp_sb_empty", sb.size(), 0);
    chk("bp_out_cnt", 32'(outc_v[2]), 32'h2);
    chk("bp_ones", 32'(ones_v[2]), 32'h10);
    chk("bp_leftover", 32'(left_v[2]), 32'h0);
    chk("bp_valid_low", 32'(out_valid_v[2]), 32'h0);

    // reset during PAIR1 of byte 0, start held high on the reset edge
    mem[0] = 8'h9A; mem[1] = 8'h6C; mem[2] = 8'h33; mem[3] = 8'hF0;
    sel = 2;
    start_v[2] = 1'b1;
    @(posedge clk);
    #1;
    start_v[2] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    start_v[2] = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    start_v[2] = 1'b0;
    chk("midrst_outputs", {out_byte_v[2], 2'(ram_addr_v[2]), out_valid_v[2], busy_v[2], done_v[2]}, 32'h0);
    chk("midrst_counters", {11'(ones_v[2]), 11'(outc_v[2]), left_v[2]}, 32'h0);
    @(posedge clk);
    #1;
    chk("midrst_start_ignored", 32'(busy_v[2]), 32'h0);
    mem[0] = 8'h6C; mem[1] = 8'hB1; mem[2] = 8'h2D; mem[3] = 8'hE4;
    build(4);
    chk("model_6c_byte", 32'(exp_bytes[0]), 32'h6A);
    chk("model_6c_time", vt[0], 23);
    run_timed(2, 4, 1'b0);
    chk("after_rst_ones", 32'(ones_v[2]), 32'h10);
    chk("after_rst_out_cnt", 32'(outc_v[2]), 32'h1);

    // start pulsed twice while busy, every pair differs
    mem[0] = 8'h96; mem[1] = 8'h69; mem[2] = 8'hA5; mem[3] = 8'h5A;
    build(4);
    chk("model_96_byte0", 32'(exp_bytes[0]), 32'h96);
    chk("model_96_byte1", 32'(exp_bytes[1]), 32'hC3);
    run_timed(2, 4, 1'b1);
    chk("busy_start_out_cnt", 32'(outc_v[2]), 32'h2);
    chk("busy_start_idle", 32'(busy_v[2]), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
